// File: rtl/vga_timing_if.sv
// Pixel-strobe input and timing outputs of the VGA timing generator.
// The generator uses the master view; a pixel pipeline or bench uses the slave view.
interface vga_timing_if #(
  parameter int unsigned CW = 10
);
  logic          pix_en;
  logic          hsync;
  logic          vsync;
  logic [CW-1:0] hc;
  logic [CW-1:0] vc;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          video_on;
  logic          line_start;
  logic          frame_start;
  logic          vblank;

  modport master (
    input  pix_en,
    output hsync, vsync, hc, vc, x, y, video_on, line_start, frame_start, vblank
  );

  modport slave (
    output pix_en,
    input  hsync, vsync, hc, vc, x, y, video_on, line_start, frame_start, vblank
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parameterised VGA raster timing generator, advanced by a pixel strobe.
// All outputs are registered from next-state counter values, so they match hc/vc in the same cycle.
module vga_timing_gen #(
  parameter int unsigned CW       = 10,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 29,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic         clk,
  input  logic         RESET,
  vga_timing_if.master vga
);

  localparam int unsigned H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned H_ACT_START = H_SYNC + H_BP;
  localparam int unsigned H_ACT_END   = H_ACT_START + H_ACTIVE;
  localparam int unsigned V_ACT_START = V_SYNC + V_BP;
  localparam int unsigned V_ACT_END   = V_ACT_START + V_ACTIVE;

  logic [CW-1:0] hc_q, vc_q;
  logic [CW-1:0] hc_n, vc_n;
  logic [CW-1:0] x_n, y_n;
  logic          h_wrap, v_wrap;
  logic          h_act_n, v_act_n, video_on_n;

  // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    hc_n   = hc_q;
    vc_n   = vc_q;
    h_wrap = vga.pix_en && (hc_q == CW'(H_TOTAL - 1));
    v_wrap = h_wrap && (vc_q == CW'(V_TOTAL - 1));

    if (vga.pix_en) hc_n = h_wrap ? '0 : hc_q + CW'(1);
    if (h_wrap)     vc_n = v_wrap ? '0 : vc_q + CW'(1);

    h_act_n    = (hc_n >= CW'(H_ACT_START)) && (hc_n < CW'(H_ACT_END));
    v_act_n    = (vc_n >= CW'(V_ACT_START)) && (vc_n < CW'(V_ACT_END));
    video_on_n = h_act_n && v_act_n;
    x_n        = video_on_n ? hc_n - CW'(H_ACT_START) : '0;
    y_n        = video_on_n ? vc_n - CW'(V_ACT_START) : '0;
  end

  // NOTE: state and output registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      hc_q            <= '0;
      vc_q            <= '0;
      vga.x           <= '0;
      vga.y           <= '0;
      vga.video_on    <= 1'b0;
      vga.line_start  <= 1'b0;
      vga.frame_start <= 1'b0;
      vga.vblank      <= 1'b1;
      vga.hsync       <= HS_POL;
      vga.vsync       <= VS_POL;
    end else begin
      hc_q            <= hc_n;
      vc_q            <= vc_n;
      vga.x           <= x_n;
      vga.y           <= y_n;
      vga.video_on    <= video_on_n;
      // Pulses come from the wrap itself, so a frozen hc=0 never re-fires them.
      vga.line_start  <= h_wrap;
      vga.frame_start <= v_wrap;
      vga.vblank      <= ~v_act_n;
      vga.hsync       <= (hc_n < CW'(H_SYNC)) ? HS_POL : ~HS_POL;
      vga.vsync       <= (vc_n < CW'(V_SYNC)) ? VS_POL : ~VS_POL;
    end
  end

  assign vga.hc = hc_q;
  assign vga.vc = vc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: four parameter sets share one clock,
// a reference raster model pushes expected outputs that are popped at the falling edge.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [15:0] hc;
    logic [15:0] vc;
    logic [15:0] x;
    logic [15:0] y;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic        vblank;
    logic        ls;
    logic        fs;
  } exp_t;

  typedef struct {
    int hs, hbp, ha, hfp;
    int vs, vbp, va, vfp;
    bit hpol, vpol;
  } cfg_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [4];

  vga_timing_if #(.CW(10)) if0 ();
  vga_timing_if #(.CW(6))  if1 ();
  vga_timing_if #(.CW(6))  if2 ();
  vga_timing_if #(.CW(11)) if3 ();

  vga_timing_gen u_def (.clk(clk), .RESET(rst[0]), .vga(if0.master));

  vga_timing_gen #(
    .CW(6), .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(2), .V_BP(2), .V_ACTIVE(5), .V_FP(2)
  ) u_small (.clk(clk), .RESET(rst[1]), .vga(if1.master));

  vga_timing_gen #(
    .CW(6), .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(2), .V_BP(2), .V_ACTIVE(5), .V_FP(2), .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_pol (.clk(clk), .RESET(rst[2]), .vga(if2.master));

  vga_timing_gen #(
    .CW(11), .H_SYNC(128), .H_BP(88), .H_ACTIVE(800), .H_FP(40),
    .V_SYNC(4), .V_BP(23), .V_ACTIVE(600), .V_FP(1)
  ) u_svga (.clk(clk), .RESET(rst[3]), .vga(if3.master));

  cfg_t cfg [4];
  int   m_hc [4];
  int   m_vc [4];
  exp_t sb [$];
  int   checks   = 0;
  int   failures = 0;

  function automatic int h_total(int idx);
    return cfg[idx].hs + cfg[idx].hbp + cfg[idx].ha + cfg[idx].hfp;
  endfunction

  function automatic int v_total(int idx);
    return cfg[idx].vs + cfg[idx].vbp + cfg[idx].va + cfg[idx].vfp;
  endfunction

  function automatic exp_t model_out(int idx, bit ls, bit fs);
    exp_t e;
    cfg_t c = cfg[idx];
    int   h = m_hc[idx];
    int   v = m_vc[idx];
    bit   h_act = (h >= c.hs + c.hbp) && (h < c.hs + c.hbp + c.ha);
    bit   v_act = (v >= c.vs + c.vbp) && (v < c.vs + c.vbp + c.va);
    e.hc       = 16'(h);
    e.vc       = 16'(v);
    e.video_on = h_act && v_act;
    e.x        = e.video_on ? 16'(h - c.hs - c.hbp) : 16'd0;
    e.y        = e.video_on ? 16'(v - c.vs - c.vbp) : 16'd0;
    e.hsync    = (h < c.hs) ? c.hpol : !c.hpol;
    e.vsync    = (v < c.vs) ? c.vpol : !c.vpol;
    e.vblank   = !v_act;
    e.ls       = ls;
    e.fs       = fs;
    return e;
  endfunction

  `define OBS(IFN) begin e.hc = 16'(IFN.hc); e.vc = 16'(IFN.vc); e.x = 16'(IFN.x); \
    e.y = 16'(IFN.y); e.hsync = IFN.hsync; e.vsync = IFN.vsync; e.video_on = IFN.video_on; \
    e.vblank = IFN.vblank; e.ls = IFN.line_start; e.fs = IFN.frame_start; end

  function automatic exp_t observe(int idx);
    exp_t e = '0;
    case (idx)
      0:       `OBS(if0)
      1:       `OBS(if1)
      2:       `OBS(if2)
      default: `OBS(if3)
    endcase
    return e;
  endfunction

  function automatic string fmt(exp_t e);
    return $sformatf("hc=%0d vc=%0d x=%0d y=%0d hs=%b vs=%b von=%b vb=%b ls=%b fs=%b",
                     e.hc, e.vc, e.x, e.y, e.hsync, e.vsync, e.video_on, e.vblank, e.ls, e.fs);
  endfunction

  task automatic set_pen(int idx, bit v);
    case (idx)
      0:       if0.pix_en = v;
      1:       if1.pix_en = v;
      2:       if2.pix_en = v;
      default: if3.pix_en = v;
    endcase
  endtask

  // One clk: drive pix_en, advance the model at the edge and queue its prediction,
  // then pop it at the falling edge alongside the sampled DUT outputs.
  task automatic step(int idx, bit pen, output exp_t obs, output exp_t exp);
    bit ls = 1'b0;
    bit fs = 1'b0;
    set_pen(idx, pen);
    @(posedge clk);
    if (pen) begin
      if (m_hc[idx] == h_total(idx) - 1) begin
        ls = 1'b1;
        m_hc[idx] = 0;
        if (m_vc[idx] == v_total(idx) - 1) begin
          fs = 1'b1;
          m_vc[idx] = 0;
        end else begin
          m_vc[idx]++;
        end
      end else begin
        m_hc[idx]++;
      end
    end
    sb.push_back(model_out(idx, ls, fs));
    @(negedge clk);
    obs = observe(idx);
    exp = sb.pop_front();
  endtask

  task automatic test_reset();
    exp_t obs, exp;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      obs = observe(i);
      exp = model_out(i, 1'b0, 1'b0);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL reset_state[%0d]: got %s expected %s", i, fmt(obs), fmt(exp));
      end
    end
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      obs = observe(i);
      checks++;
      if (obs !== exp_t'(model_out(i, 1'b0, 1'b0))) begin
        failures++;
        $display("FAIL reset_release_hold[%0d]: got %s", i, fmt(obs));
      end
    end
  endtask

  task automatic test_frames();
    exp_t obs, exp;
    int   last_fs = -1;
    int   nfs = 0;
    int   nls = 0;
    int   ftot = h_total(1) * v_total(1);
    for (int n = 0; n < 3 * ftot + 2; n++) begin
      step(1, 1'b1, obs, exp);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL frames_cycle n=%0d: got %s expected %s", n, fmt(obs), fmt(exp));
      end
      if (obs.ls) nls++;
      if (obs.fs) begin
        if (last_fs >= 0) begin
          checks++;
          if (n - last_fs !== ftot) begin
            failures++;
            $display("FAIL frame_length: got %0d clks expected %0d", n - last_fs, ftot);
          end
          checks++;
          if (nls !== v_total(1)) begin
            failures++;
            $display("FAIL line_starts_per_frame: got %0d expected %0d", nls, v_total(1));
          end
        end
        last_fs = n;
        nls = 0;
        nfs++;
      end
    end
    checks++;
    if (nfs !== 3) begin
      failures++;
      $display("FAIL frame_start_count: got %0d expected 3", nfs);
    end
    set_pen(1, 1'b0);
  endtask

  task automatic test_pix_en_toggle();
    exp_t obs, exp;
    int   last_fs = -1;
    int   nfs = 0;
    bit   prev_ls = 1'b0;
    int   ftot = 2 * h_total(1) * v_total(1);
    for (int n = 0; n < 3 * ftot + 4; n++) begin
      step(1, (n % 2) == 0, obs, exp);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL toggle_cycle n=%0d: got %s expected %s", n, fmt(obs), fmt(exp));
      end
      if (prev_ls && obs.ls) begin
        failures++;
        $display("FAIL line_start_width: got 2+ clks expected 1 at n=%0d", n);
      end
      prev_ls = obs.ls;
      if (obs.fs) begin
        if (last_fs >= 0) begin
          checks++;
          if (n - last_fs !== ftot) begin
            failures++;
            $display("FAIL toggle_frame_length: got %0d clks expected %0d", n - last_fs, ftot);
          end
        end
        last_fs = n;
        nfs++;
      end
    end
    checks++;
    if (nfs < 2) begin
      failures++;
      $display("FAIL toggle_frame_count: got %0d expected >=2", nfs);
    end
    set_pen(1, 1'b0);
  endtask

  task automatic test_polarity();
    exp_t obs, exp;
    int   hs_hi = 0;
    int   vs_hi = 0;
    for (int n = 0; n < h_total(2) * v_total(2); n++) begin
      step(2, 1'b1, obs, exp);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL polarity_cycle n=%0d: got %s expected %s", n, fmt(obs), fmt(exp));
      end
      if (obs.hsync === 1'b1) hs_hi++;
      if (obs.vsync === 1'b1) vs_hi++;
    end
    checks++;
    if (hs_hi !== 4 * 11) begin
      failures++;
      $display("FAIL hsync_high_clks: got %0d expected %0d", hs_hi, 4 * 11);
    end
    checks++;
    if (vs_hi !== 2 * 17) begin
      failures++;
      $display("FAIL vsync_high_clks: got %0d expected %0d", vs_hi, 2 * 17);
    end
    set_pen(2, 1'b0);
  endtask

  task automatic run_to(int idx, int vc_t, int hc_t, int budget, string tag);
    exp_t obs, exp;
    int   n = 0;
    while (!(m_vc[idx] == vc_t && m_hc[idx] == hc_t) && n < budget) begin
      step(idx, 1'b1, obs, exp);
      n++;
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL %s_cycle n=%0d: got %s expected %s", tag, n, fmt(obs), fmt(exp));
      end
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_timeout: got budget %0d expired expected vc=%0d hc=%0d", tag, budget, vc_t, hc_t);
    end
  endtask

  task automatic test_active_default();
    exp_t obs, exp;
    int   first_hc = -1;
    int   first_x = -1;
    int   last_hc = -1;
    int   last_x = -1;
    int   last_y = -1;
    run_to(0, 31, 0, 30000, "to_line31");
    for (int n = 0; n < 800; n++) begin
      step(0, 1'b1, obs, exp);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL line31_cycle n=%0d: got %s expected %s", n, fmt(obs), fmt(exp));
      end
      if (obs.video_on === 1'b1) begin
        if (first_hc < 0) begin
          first_hc = int'(obs.hc);
          first_x  = int'(obs.x);
        end
        last_hc = int'(obs.hc);
        last_x  = int'(obs.x);
        last_y  = int'(obs.y);
      end
    end
    checks++;
    if (first_hc !== 144 || first_x !== 0) begin
      failures++;
      $display("FAIL video_on_rise: got hc=%0d x=%0d expected hc=144 x=0", first_hc, first_x);
    end
    checks++;
    if (last_hc !== 783 || last_x !== 639) begin
      failures++;
      $display("FAIL video_on_last: got hc=%0d x=%0d expected hc=783 x=639", last_hc, last_x);
    end
    checks++;
    if (last_y !== 0) begin
      failures++;
      $display("FAIL line31_y: got %0d expected 0", last_y);
    end
  endtask

  task automatic test_reset_mid();
    exp_t obs, exp;
    run_to(0, 32, 500, 2000, "to_hc500");
    set_pen(0, 1'b1);
    #2 rst[0] = 1'b1;
    #1;
    obs = observe(0);
    m_hc[0] = 0;
    m_vc[0] = 0;
    exp = model_out(0, 1'b0, 1'b0);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL async_reset: got %s expected %s", fmt(obs), fmt(exp));
    end
    @(negedge clk);
    rst[0] = 1'b0;
    step(0, 1'b1, obs, exp);
    checks++;
    if (obs !== exp || obs.hc !== 16'd1 || obs.vc !== 16'd0 || obs.fs !== 1'b0) begin
      failures++;
      $display("FAIL restart_after_reset: got %s expected %s", fmt(obs), fmt(exp));
    end
    set_pen(0, 1'b0);
  endtask

  task automatic test_svga();
    exp_t obs, exp;
    int   last_ls = -1;
    int   max_x = -1;
    int   n = 0;
    while (!(m_vc[3] == 28 && m_hc[3] == 0) && n < 32000) begin
      step(3, 1'b1, obs, exp);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL svga_cycle n=%0d: got %s expected %s", n, fmt(obs), fmt(exp));
      end
      if (obs.video_on === 1'b1 && int'(obs.x) > max_x) max_x = int'(obs.x);
      if (obs.ls === 1'b1) begin
        if (last_ls >= 0) begin
          checks++;
          if (n - last_ls !== 1056) begin
            failures++;
            $display("FAIL svga_line_length: got %0d expected 1056", n - last_ls);
          end
        end
        last_ls = n;
      end
      n++;
    end
    checks++;
    if (n >= 32000) begin
      failures++;
      $display("FAIL svga_timeout: got %0d clks expected line 28 reached", n);
    end
    checks++;
    if (max_x !== 799) begin
      failures++;
      $display("FAIL svga_x_max: got %0d expected 799", max_x);
    end
    checks++;
    if (m_vc[3] !== 28 || h_total(3) * v_total(3) !== 1056 * 628) begin
      failures++;
      $display("FAIL svga_totals: got vc=%0d expected 28", m_vc[3]);
    end
    set_pen(3, 1'b0);
  endtask

  initial begin
    cfg[0] = '{hs: 96,  hbp: 48, ha: 640, hfp: 16, vs: 2, vbp: 29, va: 480, vfp: 10, hpol: 1'b0, vpol: 1'b0};
    cfg[1] = '{hs: 4,   hbp: 3,  ha: 8,   hfp: 2,  vs: 2, vbp: 2,  va: 5,   vfp: 2,  hpol: 1'b0, vpol: 1'b0};
    cfg[2] = '{hs: 4,   hbp: 3,  ha: 8,   hfp: 2,  vs: 2, vbp: 2,  va: 5,   vfp: 2,  hpol: 1'b1, vpol: 1'b1};
    cfg[3] = '{hs: 128, hbp: 88, ha: 800, hfp: 40, vs: 4, vbp: 23, va: 600, vfp: 1,  hpol: 1'b0, vpol: 1'b0};
    for (int i = 0; i < 4; i++) begin
      rst[i]  = 1'b1;
      m_hc[i] = 0;
      m_vc[i] = 0;
      set_pen(i, 1'b0);
    end

    test_reset();
    test_frames();
    test_pix_en_toggle();
    test_polarity();
    test_active_default();
    test_reset_mid();
    test_svga();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter CW, default 10, width of hc, vc, x and y.
REQ-002 SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-003 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-004 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-005 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-006 SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-007 SHALL have parameter V_BP, default 29, vertical back porch in lines.
REQ-008 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-009 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-010 SHALL have parameters HS_POL and VS_POL, default 0, sync active level (0 = active-low).
REQ-011 SHALL have port clk, input, 1, system clock; the block runs on one clock, rising edge.
REQ-012 SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-013 SHALL have port pix_en, input, 1, pixel strobe; timing advances only on clk edges where pix_en=1.
REQ-014 SHALL have ports hsync and vsync, output, 1 each, sync pulses at the configured polarity.
REQ-015 SHALL have ports hc and vc, output, CW each, raw horizontal and vertical counters.
REQ-016 SHALL have ports x and y, output, CW each, active-area pixel coordinates.
REQ-017 SHALL have port video_on, output, 1, high inside the active area.
REQ-018 SHALL have ports line_start and frame_start, output, 1 each, single-clk pulses.
REQ-019 SHALL have port vblank, output, 1, high on every line outside the active lines.

Function
REQ-020 SHALL define H_TOTAL=H_SYNC+H_BP+H_ACTIVE+H_FP (default 800) and V_TOTAL=V_SYNC+V_BP+V_ACTIVE+V_FP (default 521).
REQ-021 SHALL count hc 0..H_TOTAL-1 on pix_en, wrapping to 0 after H_TOTAL-1; hc holds when pix_en=0.
REQ-022 SHALL increment vc in the same clk edge on which hc wraps (pix_en=1 and hc=H_TOTAL-1), wrapping from V_TOTAL-1 to 0; there is no one-line lag.
REQ-023 SHALL order each line as sync [0,H_SYNC), back porch, active [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), then front porch; default active hc range is 144..783 inclusive.
REQ-024 SHALL order vertical phases the same way; default active vc range is 31..510 inclusive and vsync spans vc 0..1.
REQ-025 SHALL drive hsync=HS_POL while hc<H_SYNC, and ~HS_POL otherwise; vsync SHALL follow the same rule with vc, V_SYNC and VS_POL.
REQ-026 SHALL drive video_on=1 exactly when both hc and vc are in their active ranges, including both range boundaries.
REQ-027 SHALL drive x=hc-(H_SYNC+H_BP) and y=vc-(V_SYNC+V_BP) while video_on=1, and x=y=0 otherwise.
REQ-028 SHALL drive vblank=1 exactly when vc is outside the active vertical range, independent of hc.
REQ-029 SHALL make every output a flip-flop output that is consistent with the current hc/vc value in the same cycle; the registers are computed from next-state values, and there is no output lag relative to the counters.
REQ-030 SHALL assert line_start for exactly one clk cycle, the cycle following the edge that moved hc to 0; it SHALL NOT re-assert while pix_en=0 holds hc at 0.
REQ-031 SHALL assert frame_start for one clk cycle, coincident with line_start, only when vc also became 0.
REQ-032 SHALL make pix_en=0 freeze all counters and level outputs; line_start and frame_start SHALL go to 0 during that time.
REQ-033 SHALL require each timing parameter >=1, H_TOTAL<=2^CW and V_TOTAL<=2^CW; behaviour is undefined otherwise.

Reset
REQ-034 SHALL, while RESET=1, immediately force hc=0, vc=0, x=0, y=0, video_on=0, line_start=0, frame_start=0, vblank=1, hsync=HS_POL and vsync=VS_POL.
REQ-035 SHALL, on RESET deassertion mid-frame, resume at hc=0/vc=0 on the next pix_en edge (hc becomes 1); no frame_start is issued for the reset origin.

Verification
REQ-036 SHALL cover: defaults with pix_en=1 for 2 frames -> exactly 800x521 clks per frame, one frame_start per frame, 521 line_start pulses per frame.
REQ-037 SHALL cover: defaults, observe line 31 -> video_on rises at hc=144 with x=0, last high at hc=783 with x=639, and y=0; on line 510, y=479.
REQ-038 SHALL cover: pix_en toggling every second clk -> frame length is 833,600 clks, and each line_start stays exactly one clk wide.
REQ-039 SHALL cover: HS_POL=1, VS_POL=1 -> hsync is high for hc 0..95 and vsync is high for vc 0..1.
REQ-040 SHALL cover: RESET pulsed at hc=500, vc=300 -> all outputs reach their reset values asynchronously, and counting restarts from 0,0.
REQ-041 SHALL cover: H_ACTIVE=800, H_FP=40, H_SYNC=128, H_BP=88, V_ACTIVE=600, V_FP=1, V_SYNC=4, V_BP=23, CW=11 -> 1056x628 totals and x max=799.
